dm_cache_tag_ctrl: RTL and testbench

//  Requester side of the direct-mapped cache tag store: accepts CPU requests, drives tag-store index/write-enable/write data,

---
 rtl/dm_cache_tag_ctrl.sv | 139 +++++++++++++
 tb/tb_dm_cache_tag_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_tag_ctrl.sv
// Direct-mapped cache tag controller: CPU request intake, hit/miss decision against the
// external tag store, write-back/allocate sequencing to memory and saturating hit/miss counters.
module dm_cache_tag_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 10,
  parameter int OFFS_W  = 4,
  parameter int TAG_W   = ADDR_W - INDEX_W - OFFS_W,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic              cpu_req_rw,
  output logic              cpu_res_valid,
  output logic              cpu_res_hit,
  output logic [INDEX_W-1:0] tag_req_index,
  output logic              tag_req_we,
  output logic              tag_wr_valid,
  output logic              tag_wr_dirty,
  output logic [TAG_W-1:0]  tag_wr_tag,
  input  logic              tag_rd_valid,
  input  logic              tag_rd_dirty,
  input  logic [TAG_W-1:0]  tag_rd_tag,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] COMPARE    = 2'd1;
  localparam logic [1:0] WRITE_BACK = 2'd2;
  localparam logic [1:0] ALLOCATE   = 2'd3;

  logic [1:0]               state;
  logic [1:0]               state_nxt;
  logic [ADDR_W-OFFS_W-1:0] blk_p0;
  logic                     rw_p0;
  logic                     miss_p0;
  logic [TAG_W-1:0]         victim_p0;
  logic [INDEX_W-1:0]       index;
  logic [TAG_W-1:0]         tag;
  logic                     hit;
  logic                     accept;
  logic                     unused_offs;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign index       = blk_p0[INDEX_W-1:0];
  assign tag         = blk_p0[ADDR_W-OFFS_W-1:INDEX_W];
  assign hit         = tag_rd_valid && (tag_rd_tag == tag);
  assign accept      = (state == IDLE) && cpu_req_valid;
  assign unused_offs = ^cpu_req_addr[OFFS_W-1:0];

  always_comb begin
    state_nxt     = state;
    cpu_req_ready = (state == IDLE);
    cpu_res_valid = 1'b0;
    cpu_res_hit   = 1'b0;
    tag_req_index = (state == IDLE) ? '0 : index;
    tag_req_we    = 1'b0;
    tag_wr_valid  = 1'b0;
    tag_wr_dirty  = 1'b0;
    tag_wr_tag    = '0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    case (state)
      IDLE: begin
        if (cpu_req_valid) state_nxt = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          cpu_res_valid = 1'b1;
          cpu_res_hit   = ~miss_p0;
          if (rw_p0) begin
            tag_req_we   = 1'b1;
            tag_wr_valid = 1'b1;
            tag_wr_dirty = 1'b1;
            tag_wr_tag   = tag;
          end
          state_nxt = IDLE;
        end else begin
          // The new tag is installed up front so the post-fill re-lookup is guaranteed to hit.
          tag_req_we   = 1'b1;
          tag_wr_valid = 1'b1;
          tag_wr_dirty = rw_p0;
          tag_wr_tag   = tag;
          state_nxt    = (tag_rd_valid && tag_rd_dirty) ? WRITE_BACK : ALLOCATE;
        end
      end
      WRITE_BACK: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {victim_p0, index, {OFFS_W{1'b0}}};
        if (mem_req_ready) state_nxt = ALLOCATE;
      end
      default: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = {tag, index, {OFFS_W{1'b0}}};
        if (mem_req_ready) state_nxt = COMPARE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      miss_p0  <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) miss_p0 <= 1'b0;
      if (state == COMPARE && !hit) miss_p0 <= 1'b1;
      // Only the first lookup of a request is counted; the re-lookup after a fill is not.
      if (state == COMPARE && !miss_p0) begin
        if (hit) hit_cnt <= sat_inc(hit_cnt);
        else     miss_cnt <= sat_inc(miss_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      blk_p0 <= cpu_req_addr[ADDR_W-1:OFFS_W];
      rw_p0  <= cpu_req_rw;
    end
    if (state == COMPARE && !hit) victim_p0 <= tag_rd_tag;
  end

endmodule

// File: tb/tb_dm_cache_tag_ctrl.sv
// Bench for dm_cache_tag_ctrl: behavioural tag-store and memory responder, with a
// per-block reference model predicting hits, memory traffic, tag writes and counters.
module tb_dm_cache_tag_ctrl;
  localparam int ADDR_W = 32, INDEX_W = 10, OFFS_W = 4, TAG_W = 18, CNT_W = 32;

  logic clk, rst;
  logic cpu_req_valid, cpu_req_ready, cpu_req_rw;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic cpu_res_valid, cpu_res_hit;
  logic [INDEX_W-1:0] tag_req_index;
  logic tag_req_we, tag_wr_valid, tag_wr_dirty;
  logic [TAG_W-1:0] tag_wr_tag;
  logic tag_rd_valid, tag_rd_dirty;
  logic [TAG_W-1:0] tag_rd_tag;
  logic mem_req_valid, mem_req_rw, mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  dm_cache_tag_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_rw(cpu_req_rw),
    .cpu_res_valid(cpu_res_valid), .cpu_res_hit(cpu_res_hit),
    .tag_req_index(tag_req_index), .tag_req_we(tag_req_we),
    .tag_wr_valid(tag_wr_valid), .tag_wr_dirty(tag_wr_dirty), .tag_wr_tag(tag_wr_tag),
    .tag_rd_valid(tag_rd_valid), .tag_rd_dirty(tag_rd_dirty), .tag_rd_tag(tag_rd_tag),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tag store environment, written only by the DUT
  logic             st_v [1024];
  logic             st_d [1024];
  logic [TAG_W-1:0] st_t [1024];
  assign tag_rd_valid = st_v[tag_req_index];
  assign tag_rd_dirty = st_d[tag_req_index];
  assign tag_rd_tag   = st_t[tag_req_index];
  always @(posedge clk) begin
    if (tag_req_we) begin
      st_v[tag_req_index] <= tag_wr_valid;
      st_d[tag_req_index] <= tag_wr_dirty;
      st_t[tag_req_index] <= tag_wr_tag;
    end
  end

  // Reference model of cache contents and counters
  bit               m_v [1024];
  bit               m_d [1024];
  logic [TAG_W-1:0] m_t [1024];
  longint exp_hits, exp_misses;
  int n_asrt, n_fail;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_ready"}, cpu_req_ready, 1);
    chk({pfx, "_res_valid"}, cpu_res_valid, 0);
    chk({pfx, "_res_hit"}, cpu_res_hit, 0);
    chk({pfx, "_tag_we"}, tag_req_we, 0);
    chk({pfx, "_tag_index"}, tag_req_index, 0);
    chk({pfx, "_tag_wr"}, {tag_wr_valid, tag_wr_dirty, tag_wr_tag}, 0);
    chk({pfx, "_mem_valid"}, mem_req_valid, 0);
    chk({pfx, "_mem_rw_addr"}, {mem_req_rw, mem_req_addr}, 0);
    chk({pfx, "_hit_cnt"}, hit_cnt, 0);
    chk({pfx, "_miss_cnt"}, miss_cnt, 0);
  endtask

  // Issues one request from a negedge and follows it until the controller is idle again.
  task automatic req(input logic [31:0] a, input logic rw, input int dly, input bit keep);
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tg;
    bit    exp_hit, exp_wb;
    int    exp_we;
    int    w, cyc, wait_n, nmem, rdy_cyc, res_cyc, we_n;
    logic  res_hit_s;
    logic [31:0] mem_a [2];
    logic  mem_rw_s [2];
    logic [31:0] first_a;
    logic  first_rw;
    logic [TAG_W+1:0] wr_s;
    bit    bad_rdy, bad_idx, bad_stable;
    idx = INDEX_W'((a >> OFFS_W) % 1024);
    tg  = TAG_W'(a >> (OFFS_W + INDEX_W));
    exp_hit = m_v[idx] && (m_t[idx] == tg);
    exp_wb  = !exp_hit && m_v[idx] && m_d[idx];
    exp_we  = (exp_hit ? 0 : 1) + (rw ? 1 : 0);
    cyc = 0; wait_n = 0; nmem = 0; rdy_cyc = -1; res_cyc = -1; we_n = 0;
    bad_rdy = 0; bad_idx = 0; bad_stable = 0;
    cpu_req_valid = 1'b1; cpu_req_addr = a; cpu_req_rw = rw;
    w = 0;
    while (cpu_req_ready !== 1'b1 && w < 50) begin
      @(negedge clk); w++;
    end
    chk("accept_ready", cpu_req_ready, 1);
    @(posedge clk); #1;
    if (!keep) cpu_req_valid = 1'b0;
    while (res_cyc < 0 && cyc < 200) begin
      @(negedge clk); cyc++;
      mem_req_ready = 1'b0;
      if (cpu_req_ready !== 1'b0) bad_rdy = 1;
      if (tag_req_index !== idx) bad_idx = 1;
      if (tag_req_we === 1'b1) begin
        we_n++;
        wr_s = {tag_wr_valid, tag_wr_dirty, tag_wr_tag};
      end
      if (cpu_res_valid === 1'b1) begin
        res_cyc = cyc; res_hit_s = cpu_res_hit;
      end
      if (mem_req_valid === 1'b1) begin
        if (wait_n == 0) begin
          first_a = mem_req_addr; first_rw = mem_req_rw;
        end else if (mem_req_addr !== first_a || mem_req_rw !== first_rw) bad_stable = 1;
        if (wait_n >= dly) begin
          mem_req_ready = 1'b1;
          if (nmem < 2) begin
            mem_a[nmem] = mem_req_addr; mem_rw_s[nmem] = mem_req_rw;
          end
          nmem++; rdy_cyc = cyc; wait_n = 0;
        end else wait_n++;
      end
    end
    chk("res_seen", res_cyc >= 0, 1);
    chk("res_hit", res_hit_s, exp_hit);
    chk("res_latency", res_cyc, exp_hit ? 1 : rdy_cyc + 1);
    chk("mem_req_count", nmem, exp_hit ? 0 : (exp_wb ? 2 : 1));
    if (exp_wb) begin
      chk("wb_addr", {mem_rw_s[0], mem_a[0]}, {1'b1, m_t[idx], idx, 4'h0});
      chk("fill_addr", {mem_rw_s[1], mem_a[1]}, {1'b0, tg, idx, 4'h0});
    end else if (!exp_hit) begin
      chk("fill_addr", {mem_rw_s[0], mem_a[0]}, {1'b0, tg, idx, 4'h0});
    end
    chk("busy_ready_low", bad_rdy, 0);
    chk("busy_index", bad_idx, 0);
    chk("mem_req_stable", bad_stable, 0);
    chk("tag_we_count", we_n, exp_we);
    if (exp_we > 0) chk("tag_wr_data", wr_s, {1'b1, rw, tg});
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("res_one_pulse", cpu_res_valid, 0);
    chk("idle_ready", cpu_req_ready, 1);
    m_d[idx] = rw || (exp_hit && m_d[idx]);
    m_v[idx] = 1'b1;
    m_t[idx] = tg;
    if (exp_hit) exp_hits++; else exp_misses++;
    chk("hit_cnt", hit_cnt, exp_hits);
    chk("miss_cnt", miss_cnt, exp_misses);
    chk("store_entry", {st_v[idx], st_d[idx], st_t[idx]}, {m_v[idx], m_d[idx], m_t[idx]});
  endtask

  initial begin
    int w;
    logic [TAG_W-1:0]   rt;
    logic [INDEX_W-1:0] ri;
    logic [OFFS_W-1:0]  ro;
    n_asrt = 0; n_fail = 0; exp_hits = 0; exp_misses = 0;
    for (int i = 0; i < 1024; i++) begin
      st_v[i] = 1'b0; st_d[i] = 1'b0; st_t[i] = '0;
      m_v[i] = 1'b0; m_d[i] = 1'b0; m_t[i] = '0;
    end
    rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_rw = 1'b0; mem_req_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Memory ready while idle must not provoke anything.
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("idle_memrdy_valid", mem_req_valid, 0);
    chk("idle_memrdy_ready", cpu_req_ready, 1);
    mem_req_ready = 1'b0;

    req(32'h0000_1230, 1'b0, 3, 1'b0);
    req(32'h0000_1234, 1'b0, 0, 1'b0);
    req(32'h0000_1230, 1'b1, 1, 1'b0);
    req(32'h0000_5230, 1'b0, 2, 1'b0);
    req(32'h0000_9230, 1'b0, 1, 1'b1);
    req(32'h0000_9230, 1'b0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rt = TAG_W'($urandom_range(0, 3));
      ri = INDEX_W'($urandom_range(32'h120, 32'h123));
      ro = OFFS_W'($urandom_range(0, 15));
      req({rt, ri, ro}, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset in the middle of a write-back.
    req(32'h0000_0450, 1'b1, 0, 1'b0);
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h0001_0450; cpu_req_rw = 1'b0;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    w = 0;
    while (!(mem_req_valid === 1'b1 && mem_req_rw === 1'b1) && w < 20) begin
      @(negedge clk); w++;
    end
    chk("wb_started", {mem_req_valid, mem_req_rw, mem_req_addr}, {2'b11, 32'h0000_0450});
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midop_reset");
    rst = 1'b0;
    m_v[10'h045] = 1'b1; m_d[10'h045] = 1'b0; m_t[10'h045] = 18'h4;
    exp_hits = 0; exp_misses = 0;
    req(32'h0001_0450, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
